rf_writeback_unit: RTL and testbench
====================================

# rf_writeback_unit

Writeback arbiter for the pipelined RV64 core: the write-side producer that drives the register file's single write port (`RegWrite`, `write_reg`, `write_data`). It merges same-cycle ALU results from the MEM/WB stage with variable-latency load responses from data memory. Load responses are buffered in a small FIFO and, when the load-extension feature is compiled in, byte-aligned and sign/zero-extended. A pending-load scoreboard is exported to the hazard unit for stall decisions.

## Interface
- `XLEN`, 64, datapath width
- `DEPTH`, 4, load-response FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle (always accepted)
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `ld_issue`  in  1  load issued to memory this cycle
- `ld_issue_rd`  in  5  destination of issued load
- `ld_rsp_valid`  in  1  load response valid
- `ld_rsp_ready`  out  1  FIFO can accept
- `ld_rsp_rd`  in  5  response destination
- `ld_rsp_data`  in  XLEN  raw 64-bit memory doubleword
- `ld_rsp_funct3`  in  3  load type
- `ld_rsp_addr_lo`  in  3  byte offset within doubleword
- `RegWrite`  out  1  RF write enable (registered)
- `write_reg`  out  5  RF write index (registered)
- `write_data`  out  XLEN  RF write data (registered)
- `pend_mask`  out  32  bit r set = load to xr outstanding
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (async, `nrst`=0): `RegWrite`=0, `write_reg`=0, `write_data`=0, `pend_mask`=0, FIFO emptied (`fifo_count`=0, `ld_rsp_ready`=1). Reset mid-operation discards all buffered responses and pending bits.
- Response accepted on an edge with `ld_rsp_valid & ld_rsp_ready`; the value (extended per Configuration), rd pushed to FIFO tail.
- `ld_rsp_ready` = `fifo_count < DEPTH`, combinational from count only; when full, no push even if a pop occurs in the same cycle.
- Arbitration each cycle: `alu_valid` has strict priority; otherwise, FIFO head popped if non-empty; otherwise, idle (`RegWrite`=0, `write_reg`/`write_data` hold last value).
- Destination x0: the selected source is consumed (ALU dropped, FIFO popped) but `RegWrite`=0.
- Scoreboard: `ld_issue` with `ld_issue_rd`≠0 sets bit at the edge; popping a FIFO entry clears its rd bit at that edge. Simultaneous set and clear of the same bit: set wins. An ALU write never touches `pend_mask`.
- FIFO pointers wrap modulo DEPTH; push and pop in the same cycle keep count constant.

## Timing
- ALU: `alu_valid` sampled at edge N → `RegWrite`/`write_*` valid after edge N, i.e. during cycle N+1 (1-cycle latency).
- Load: accepted at edge N; earliest pop at edge N+1 → `RegWrite` during cycle N+2. No FIFO bypass.
- `pend_mask` bit clears on the same edge that registers the load's write, so RF and scoreboard update together.
- Sustained `alu_valid` starves the FIFO indefinitely; the hazard unit guarantees bubbles.

## Configuration
- `WB_LOAD_EXT_EN` defined: extension is applied at push time.
  - funct3 000 LB/100 LBU: byte at `addr_lo`*8
  - 001 LH/101 LHU: half at `addr_lo[2:1]`*16
  - 010 LW/110 LWU: word at `addr_lo[2]`*32
  - 011 LD and 111: full doubleword
  - Codes 000–010 sign-extend; 100–110 zero-extend.
- Undefined: `ld_rsp_data` is stored unmodified; `ld_rsp_funct3` and `ld_rsp_addr_lo` are ignored. Memory delivers pre-extended data.

## Test plan
- Reset mid-run: 3 entries buffered, `pend_mask`=0x0000_0070, pulse `nrst` low → `fifo_count`=0, `pend_mask`=0, `RegWrite`=0 immediately (async).
- ALU only: `alu_valid`=1, rd=5, data=0x1234 at edge N → cycle N+1 `RegWrite`=1, `write_reg`=5, `write_data`=0x1234; rd=0 → `RegWrite`=0.
- Priority/order: issue loads to x6, x7; responses accepted; `alu_valid` held 3 cycles → no load writes during those cycles, then x6 followed by x7 written on consecutive cycles; bits 6 and 7 clear on their write edges.
- Full FIFO: 4 responses pushed with `alu_valid` held → `ld_rsp_ready`=0, 5th response held; drop `alu_valid` → one pop per cycle, `ld_rsp_ready` returns to 1 the cycle after the first pop, wrap-around ordering preserved over 10 responses.
- Scoreboard race: an x9 load pops on the same edge a new `ld_issue` to x9 occurs → bit 9 remains set.
- Extension (macro defined): data=0x8877_6655_4433_2211, LB offset 7 → 0xFFFF_FFFF_FFFF_FF88; LHU offset 6 → 0x8877; LW offset 4 → 0xFFFF_FFFF_8877_6655. Macro undefined → raw doubleword written.

Source files
------------

// File: rtl/rf_writeback_unit.sv
// Register-file writeback arbiter: ALU results take priority, buffered load responses fill the gaps.
// Optional macro WB_LOAD_EXT_EN enables byte alignment and sign/zero extension of loads at push time.
module rf_writeback_unit #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_issue,
  input  logic [4:0]               ld_issue_rd,
  input  logic                     ld_rsp_valid,
  output logic                     ld_rsp_ready,
  input  logic [4:0]               ld_rsp_rd,
  input  logic [XLEN-1:0]          ld_rsp_data,
  input  logic [2:0]               ld_rsp_funct3,
  input  logic [2:0]               ld_rsp_addr_lo,
  output logic                     RegWrite,
  output logic [4:0]               write_reg,
  output logic [XLEN-1:0]          write_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  data_mem_q [DEPTH];
  logic [4:0]       rd_mem_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;
  logic [31:0]      pend_q, pend_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [XLEN-1:0]  push_data;
  logic [4:0]       head_rd;
  logic [XLEN-1:0]  head_data;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;

`ifdef WB_LOAD_EXT_EN
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                               input logic [2:0]      f3,
                                               input logic [2:0]      off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic        sx;
    b  = raw[{off, 3'b000} +: 8];
    h  = raw[{off[2:1], 4'b0000} +: 16];
    w  = raw[{off[2], 5'b00000} +: 32];
    sx = ~f3[2];
    case (f3[1:0])
      2'b00:   load_ext = {{(XLEN-8){sx & b[7]}}, b};
      2'b01:   load_ext = {{(XLEN-16){sx & h[15]}}, h};
      2'b10:   load_ext = {{(XLEN-32){sx & w[31]}}, w};
      default: load_ext = raw;
    endcase
  endfunction

  assign push_data = load_ext(ld_rsp_data, ld_rsp_funct3, ld_rsp_addr_lo);
`else
  // Memory already delivers extended data; funct3/offset are unused here.
  logic unused_ext;
  assign unused_ext = ^{ld_rsp_funct3, ld_rsp_addr_lo};
  assign push_data  = ld_rsp_data;
`endif

  // Response handshake: a response transfers on a rising edge where ld_rsp_valid
  // and ld_rsp_ready are both high; ready depends only on occupancy, so a pop in
  // the same cycle never frees room for a push into a full FIFO.
  assign ld_rsp_ready = (count_q < CNT_W'(DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign push         = ld_rsp_valid & ld_rsp_ready;
  assign pop          = ~alu_valid & ~fifo_empty;
  assign head_rd      = rd_mem_q[rd_ptr_q];
  assign head_data    = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Source select; x0 consumes the source but never raises the write enable.
  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_valid) begin
      regwrite_d   = (alu_rd != 5'd0);
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end else if (pop) begin
      regwrite_d   = (head_rd != 5'd0);
      write_reg_d  = head_rd;
      write_data_d = head_data;
    end
  end

  // A new issue to the same register wins over the clear from its older load.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ld_issue && (ld_issue_rd != 5'd0)) set_mask[ld_issue_rd] = 1'b1;
    if (pop) clr_mask[head_rd] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pend_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pend_q       <= pend_d;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= push_data;
      rd_mem_q[wr_ptr_q]   <= ld_rsp_rd;
    end
  end

  assign RegWrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign pend_mask  = pend_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: every register-file write is matched against an expected queue.
module tb_rf_writeback_unit;

  localparam int XLEN = 64;

  logic            clk;
  logic            nrst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_rsp_valid;
  logic            ld_rsp_ready;
  logic [4:0]      ld_rsp_rd;
  logic [XLEN-1:0] ld_rsp_data;
  logic [2:0]      ld_rsp_funct3;
  logic [2:0]      ld_rsp_addr_lo;
  logic            RegWrite;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic [31:0]     pend_mask;
  logic [2:0]      fifo_count;

  int checks   = 0;
  int failures = 0;

  logic [68:0] exp_q[$];
  logic [68:0] ld_exp[$];

  rf_writeback_unit #(.XLEN(XLEN), .DEPTH(4)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_rsp_valid   (ld_rsp_valid),
    .ld_rsp_ready   (ld_rsp_ready),
    .ld_rsp_rd      (ld_rsp_rd),
    .ld_rsp_data    (ld_rsp_data),
    .ld_rsp_funct3  (ld_rsp_funct3),
    .ld_rsp_addr_lo (ld_rsp_addr_lo),
    .RegWrite       (RegWrite),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .pend_mask      (pend_mask),
    .fifo_count     (fifo_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
    if (rd != 5'd0) exp_q.push_back({rd, data});
  endtask

  task automatic drive_rsp(input logic [4:0] rd, input logic [XLEN-1:0] data,
                           input logic [2:0] f3, input logic [2:0] off);
    ld_rsp_valid   = 1'b1;
    ld_rsp_rd      = rd;
    ld_rsp_data    = data;
    ld_rsp_funct3  = f3;
    ld_rsp_addr_lo = off;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: each observed write must be the next expected one
  always @(negedge clk) begin
    if (nrst && RegWrite) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL wb_unexpected observed rd=%0d data=%0h expected no write", write_reg, write_data);
      end
      if (exp_q.size() != 0) check("wb_stream", {write_reg, write_data}, exp_q.pop_front());
    end
  end

  initial begin
    logic [XLEN-1:0] ext_src;
    logic [XLEN-1:0] rnd;

    nrst           = 1'b0;
    alu_valid      = 1'b0;
    alu_rd         = '0;
    alu_data       = '0;
    ld_issue       = 1'b0;
    ld_issue_rd    = '0;
    ld_rsp_valid   = 1'b0;
    ld_rsp_rd      = '0;
    ld_rsp_data    = '0;
    ld_rsp_funct3  = 3'd3;
    ld_rsp_addr_lo = '0;

    // Reset state
    repeat (3) tick();
    check("rst_regwrite", RegWrite, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", ld_rsp_ready, 1);
    nrst = 1'b1;
    tick();

    // ALU-only path, x0 suppression, idle hold
    drive_alu(5'd5, 64'h1234);
    tick();
    check("alu_we", RegWrite, 1);
    check("alu_rd", write_reg, 5);
    check("alu_data", write_data, 64'h1234);
    drive_alu(5'd0, 64'hDEAD);
    tick();
    check("alu_x0_we", RegWrite, 0);
    drive_alu(5'd12, 64'hBEEF);
    tick();
    check("alu_rd12", write_reg, 12);
    alu_valid = 1'b0;
    tick();
    check("idle_we", RegWrite, 0);
    check("idle_hold_rd", write_reg, 12);
    check("idle_hold_data", write_data, 64'hBEEF);

    // Priority and ordering
    ld_issue = 1'b1; ld_issue_rd = 5'd6;
    tick();
    ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    check("pend_67", pend_mask, 32'h0000_00C0);
    drive_alu(5'd1, 64'hA1);
    drive_rsp(5'd6, 64'h6666_0000_0000_0006, 3'd3, 3'd0);
    ld_exp.push_back({5'd6, 64'h6666_0000_0000_0006});
    tick();
    drive_alu(5'd2, 64'hA2);
    drive_rsp(5'd7, 64'h7777_0000_0000_0007, 3'd3, 3'd0);
    ld_exp.push_back({5'd7, 64'h7777_0000_0000_0007});
    tick();
    ld_rsp_valid = 1'b0;
    drive_alu(5'd3, 64'hA3);
    tick();
    check("prio_count", fifo_count, 2);
    check("prio_pend", pend_mask, 32'h0000_00C0);
    alu_valid = 1'b0;
    while (ld_exp.size() != 0) exp_q.push_back(ld_exp.pop_front());
    tick();
    check("pop_x6_rd", write_reg, 6);
    check("pop_x6_pend", pend_mask, 32'h0000_0080);
    tick();
    check("pop_x7_rd", write_reg, 7);
    check("pop_x7_pend", pend_mask, 32'h0000_0000);
    check("prio_empty", fifo_count, 0);
    drain("prio_drain");

    // Full FIFO with ALU starving the pop side, then wrap-around over 10 responses
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom};
      drive_rsp(5'(16 + i), rnd, 3'd3, 3'($urandom_range(0, 7)));
      ld_exp.push_back({5'(16 + i), rnd});
      drive_alu(5'd1, 64'(100 + i));
      tick();
    end
    check("full_ready", ld_rsp_ready, 0);
    check("full_count", fifo_count, 4);
    rnd = {$urandom, $urandom};
    drive_rsp(5'd20, rnd, 3'd3, 3'd0);
    ld_exp.push_back({5'd20, rnd});
    drive_alu(5'd1, 64'd200);
    tick();
    drive_alu(5'd1, 64'd201);
    tick();
    check("held_count", fifo_count, 4);
    check("held_ready", ld_rsp_ready, 0);
    alu_valid = 1'b0;
    while (ld_exp.size() != 0) exp_q.push_back(ld_exp.pop_front());
    tick();
    check("first_pop_ready", ld_rsp_ready, 1);
    check("first_pop_count", fifo_count, 3);
    tick();
    for (int i = 5; i < 10; i++) begin
      rnd = {$urandom, $urandom};
      drive_rsp(5'(16 + i), rnd, 3'd3, 3'd0);
      exp_q.push_back({5'(16 + i), rnd});
      tick();
    end
    check("steady_count", fifo_count, 3);
    ld_rsp_valid = 1'b0;
    drain("wrap_drain");
    check("wrap_empty", fifo_count, 0);
    check("wrap_pend", pend_mask, 0);

    // Scoreboard race: pop of x9 and new issue to x9 on the same edge
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    drive_rsp(5'd9, 64'h9999, 3'd3, 3'd0);
    exp_q.push_back({5'd9, 64'h9999});
    tick();
    ld_rsp_valid = 1'b0;
    check("race_pend_before", pend_mask, 32'h0000_0200);
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    check("race_write_rd", write_reg, 9);
    check("race_pend_kept", pend_mask, 32'h0000_0200);
    drive_rsp(5'd9, 64'h9A9A, 3'd3, 3'd0);
    exp_q.push_back({5'd9, 64'h9A9A});
    tick();
    ld_rsp_valid = 1'b0;
    tick();
    check("race_pend_clear", pend_mask, 0);
    drain("race_drain");

    // Load extension
    ext_src = 64'h8877_6655_4433_2211;
    drive_rsp(5'd10, ext_src, 3'b000, 3'd7);
`ifdef WB_LOAD_EXT_EN
    exp_q.push_back({5'd10, 64'hFFFF_FFFF_FFFF_FF88});
`else
    exp_q.push_back({5'd10, ext_src});
`endif
    tick();
    drive_rsp(5'd11, ext_src, 3'b101, 3'd6);
`ifdef WB_LOAD_EXT_EN
    exp_q.push_back({5'd11, 64'h0000_0000_0000_8877});
`else
    exp_q.push_back({5'd11, ext_src});
`endif
    tick();
    drive_rsp(5'd13, ext_src, 3'b010, 3'd4);
`ifdef WB_LOAD_EXT_EN
    exp_q.push_back({5'd13, 64'hFFFF_FFFF_8877_6655});
`else
    exp_q.push_back({5'd13, ext_src});
`endif
    tick();
    ld_rsp_valid = 1'b0;
    drain("ext_drain");

    // Asynchronous reset mid-run with three buffered responses
    for (int i = 4; i < 7; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(i);
      tick();
    end
    ld_issue = 1'b0;
    for (int i = 4; i < 7; i++) begin
      drive_rsp(5'(i), 64'(i), 3'd3, 3'd0);
      drive_alu(5'd2, 64'(300 + i));
      tick();
    end
    ld_rsp_valid = 1'b0;
    check("mid_count", fifo_count, 3);
    check("mid_pend", pend_mask, 32'h0000_0070);
    #2;
    nrst = 1'b0;
    alu_valid = 1'b0;
    #1;
    check("async_count", fifo_count, 0);
    check("async_pend", pend_mask, 0);
    check("async_regwrite", RegWrite, 0);
    exp_q.delete();
    repeat (2) tick();
    nrst = 1'b1;
    check("post_rst_ready", ld_rsp_ready, 1);
    drive_alu(5'd31, 64'hCAFE);
    tick();
    alu_valid = 1'b0;
    check("post_rst_alu", {RegWrite, write_reg}, {1'b1, 5'd31});
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
